// File: rtl/ikbd_serial_pkg.sv
// Shared types and helpers for the IKBD 8N1 serial link.
// Optional internal loopback is enabled by defining IKBD_SERIAL_LOOPBACK_EN.
package ikbd_serial_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;
    // Data bit index covers up to 8 bits per character
    localparam int BIT_IDX_W = 3;

    function automatic int ikbd_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ikbd_serial_fifo.sv
// Synchronous RX FIFO with registered head, occupancy level and overrun pulse.
module ikbd_serial_fifo import ikbd_serial_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        i_push,
    input  logic [W-1:0]                i_push_data,
    input  logic                        i_pop,
    output logic [W-1:0]                o_head,
    output logic                        o_empty,
    output logic [ikbd_clog2(DEPTH):0]  o_level,
    output logic                        o_overrun
);

    localparam int AW = ikbd_clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_head;
    logic          r_overrun;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_rd_next;
    logic [LW-1:0] w_level_next;

    assign o_empty      = (r_level == '0);
    assign w_full       = (r_level == LW'(DEPTH));
    assign w_pop        = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push       = i_push && (!w_full || w_pop);
    assign w_rd_next    = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_head    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr  <= w_rd_next;
            r_level   <= w_level_next;
            r_overrun <= i_push && w_full && !w_pop;
            // Head bypasses the array when the new head is the slot being written
            if (w_level_next != '0) begin
                if (w_push && (r_wr_ptr == w_rd_next)) r_head <= i_push_data;
                else                                   r_head <= r_mem[w_rd_next];
            end
        end
    end

    assign o_head    = r_head;
    assign o_level   = r_level;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/ikbd_serial_link.sv
// 8N1 serial transceiver between the IKBD core and the host ACIA model.
// Define IKBD_SERIAL_LOOPBACK_EN to add the 'loopback' port (RX fed from internal TX bit).
module ikbd_serial_link import ikbd_serial_pkg::*; #(
    parameter int BAUD_DIV   = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8
) (
    input  logic                             clk,
    input  logic                             res,
`ifdef IKBD_SERIAL_LOOPBACK_EN
    input  logic                             loopback,
`endif
    input  logic [DATA_W-1:0]                tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             txd,
    input  logic                             rxd,
    output logic [DATA_W-1:0]                rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [ikbd_clog2(FIFO_DEPTH):0]  rx_level,
    output logic                             rx_frame_err,
    output logic                             rx_overrun
);

    localparam int             DIV_W    = ikbd_clog2(BAUD_DIV);
    localparam logic [DIV_W-1:0] CNT_FULL = DIV_W'(BAUD_DIV - 1);
    localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_W - 1);

    logic w_loopback;
`ifdef IKBD_SERIAL_LOOPBACK_EN
    assign w_loopback = loopback;
`else
    assign w_loopback = 1'b0;
`endif

    // ---------------- transmitter ----------------
    tx_state_t              r_tx_state;
    logic [DIV_W-1:0]       r_tx_cnt;
    logic [BIT_IDX_W-1:0]   r_tx_idx;
    logic [DATA_W-1:0]      r_tx_shift;
    logic                   r_tx_bit;
    logic                   r_tx_ready;
    logic                   w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == CNT_FULL);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= IDLE_LEVEL;
            r_tx_ready <= 1'b1;
        end else begin
            r_tx_cnt <= (r_tx_state == TX_IDLE || w_tx_bit_end) ? '0 : r_tx_cnt + 1'b1;
            case (r_tx_state)
                TX_IDLE: if (tx_valid) begin
                    r_tx_state <= TX_START;
                    r_tx_shift <= tx_data;
                    r_tx_bit   <= 1'b0;
                    r_tx_ready <= 1'b0;
                end
                TX_START: if (w_tx_bit_end) begin
                    r_tx_state <= TX_DATA;
                    r_tx_idx   <= '0;
                    r_tx_bit   <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                end
                TX_DATA: if (w_tx_bit_end) begin
                    if (r_tx_idx == LAST_IDX) begin
                        r_tx_state <= TX_STOP;
                        r_tx_bit   <= IDLE_LEVEL;
                    end else begin
                        r_tx_idx   <= r_tx_idx + 1'b1;
                        r_tx_bit   <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                end
                TX_STOP: if (w_tx_bit_end) begin
                    r_tx_state <= TX_IDLE;
                    r_tx_ready <= 1'b1;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign txd      = w_loopback ? IDLE_LEVEL : r_tx_bit;

    // ---------------- receiver ----------------
    rx_state_t              r_rx_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rx_prev;
    logic [DIV_W-1:0]       r_rx_cnt;
    logic [BIT_IDX_W-1:0]   r_rx_idx;
    logic [DATA_W-1:0]      r_rx_shift;
    logic                   r_frame_err;
    logic                   w_rx_line;
    logic                   w_rx_push;
    logic                   w_fifo_empty;

    // Loopback taps the internal TX bit directly, so no synchroniser is needed
    assign w_rx_line = w_loopback ? r_tx_bit : r_sync2;
    assign w_rx_push = (r_rx_state == RX_STOP) && (r_rx_cnt == CNT_FULL) && w_rx_line;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sync1     <= IDLE_LEVEL;
            r_sync2     <= IDLE_LEVEL;
            r_rx_prev   <= IDLE_LEVEL;
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_idx    <= '0;
            r_rx_shift  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rxd;
            r_sync2     <= r_sync1;
            r_rx_prev   <= w_rx_line;
            r_frame_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: if (r_rx_prev && !w_rx_line) begin
                    r_rx_state <= RX_START;
                    r_rx_cnt   <= '0;
                end
                RX_START: begin
                    if (r_rx_cnt == CNT_HALF) begin
                        r_rx_cnt   <= '0;
                        r_rx_idx   <= '0;
                        r_rx_state <= w_rx_line ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == CNT_FULL) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_line, r_rx_shift[DATA_W-1:1]};
                        if (r_rx_idx == LAST_IDX) r_rx_state <= RX_STOP;
                        else                      r_rx_idx   <= r_rx_idx + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == CNT_FULL) begin
                        r_rx_cnt <= '0;
                        if (w_rx_line) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state  <= RX_WAIT_HIGH;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                // A break holds the line low; wait for it to recover before hunting
                RX_WAIT_HIGH: if (w_rx_line) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    ikbd_serial_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_rx_fifo (
        .clk         (clk),
        .res         (res),
        .i_push      (w_rx_push),
        .i_push_data (r_rx_shift),
        .i_pop       (rx_ready),
        .o_head      (rx_data),
        .o_empty     (w_fifo_empty),
        .o_level     (rx_level),
        .o_overrun   (rx_overrun)
    );

    assign rx_valid     = !w_fifo_empty;
    assign rx_frame_err = r_frame_err;

endmodule
